rs_issue_sched: RTL

Issue scheduler for a reservation station: each cycle it picks one operand-ready RS entry and presents it to the ALU on a valid/ready handshake. It holds the grant stable until the ALU accepts it, then tells the RS to free that entry. Arbitration is rotating-priority by default, or oldest-first when age tracking is compiled in. It sits between the RS entry array and the ALU dispatch port.

---
 rtl/rs_issue_sched_pkg.sv | 15 +
 rtl/rs_rot_pick.sv | 32 +++
 rtl/rs_issue_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/rs_issue_sched_pkg.sv
// rtl/rs_issue_sched_pkg.sv - RS sizing, scheduler state encoding and a one-hot helper
package rs_issue_sched_pkg;
  localparam int RS_SIZE = 16;
  localparam int RS_BIT  = 4;

  typedef enum logic {
    RS_SCHED_IDLE = 1'b0,
    RS_SCHED_HOLD = 1'b1
  } rs_sched_state_e;

  function automatic logic [RS_SIZE-1:0] rs_onehot(input logic [RS_BIT-1:0] idx);
    rs_onehot      = '0;
    rs_onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rs_rot_pick.sv
// rtl/rs_rot_pick.sv - rotating-priority encoder: first set bit of cand at or after ptr
module rs_rot_pick
  import rs_issue_sched_pkg::*;
(
  input  logic [RS_SIZE-1:0] cand,
  input  logic [RS_BIT-1:0]  ptr,
  output logic               found,
  output logic [RS_BIT-1:0]  index
);
  // Doubling the vector turns the wrap-around search into a plain slice.
  logic [2*RS_SIZE-2:0] dbl;
  logic [RS_SIZE-1:0]   rot;
  logic [RS_BIT:0]      ptr_ext;
  logic [RS_BIT-1:0]    off;

  assign dbl     = {cand[RS_SIZE-2:0], cand};
  assign ptr_ext = {1'b0, ptr};
  assign rot     = dbl[ptr_ext +: RS_SIZE];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = RS_SIZE - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k[RS_BIT-1:0];
      end
    end
  end

  assign index = ptr + off;
endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - RS issue scheduler; RS_AGE_PRIO_EN selects oldest-first over rotating priority
module rs_issue_sched
  import rs_issue_sched_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic [RS_SIZE-1:0] ready_vec_in,
  input  logic               alloc_valid_in,
  input  logic [RS_BIT-1:0]  alloc_entry_in,
  output logic               issue_valid_out,
  output logic [RS_BIT-1:0]  issue_entry_out,
  input  logic               issue_ready_in,
  output logic               clear_valid_out,
  output logic [RS_BIT-1:0]  clear_entry_out
);
  rs_sched_state_e    state, state_nxt;
  logic [RS_BIT-1:0]  entry_q, entry_nxt;
  logic               fire;
  logic [RS_SIZE-1:0] cand;
  logic               pick_found;
  logic [RS_BIT-1:0]  pick_idx;

  assign fire = (state == RS_SCHED_HOLD) & issue_ready_in & rdy_in;
  // The fired entry is still flagged ready this cycle; the RS drops it next edge.
  assign cand = ready_vec_in & ~(fire ? rs_onehot(entry_q) : {RS_SIZE{1'b0}});

`ifdef RS_AGE_PRIO_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      older <= '0;
    end else if (rdy_in && alloc_valid_in) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        older[alloc_entry_in][j] <= 1'b0;
        older[j][alloc_entry_in] <= (j != int'(alloc_entry_in));
      end
    end
  end

  always_comb begin
    logic blk;
    blk        = 1'b0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      blk = 1'b0;
      for (int j = 0; j < RS_SIZE; j++) begin
        if (cand[j] && older[j][i]) blk = 1'b1;
      end
      if (cand[i] && !blk) begin
        pick_found = 1'b1;
        pick_idx   = i[RS_BIT-1:0];
      end
    end
  end
`else
  logic [RS_BIT-1:0] ptr_q;
  logic              unused_alloc;

  assign unused_alloc = &{1'b0, alloc_valid_in, alloc_entry_in};

  rs_rot_pick u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)   ptr_q <= '0;
    else if (fire) ptr_q <= entry_q + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    entry_nxt = entry_q;
    if (flush_in) begin
      state_nxt = RS_SCHED_IDLE;
    end else begin
      case (state)
        RS_SCHED_IDLE: begin
          if (pick_found) begin
            state_nxt = RS_SCHED_HOLD;
            entry_nxt = pick_idx;
          end
        end
        RS_SCHED_HOLD: begin
          if (fire) begin
            if (pick_found) entry_nxt = pick_idx;
            else            state_nxt = RS_SCHED_IDLE;
          end
        end
        default: state_nxt = RS_SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= RS_SCHED_IDLE;
      entry_q <= '0;
    end else if (rdy_in) begin
      state   <= state_nxt;
      entry_q <= entry_nxt;
    end
  end

  assign issue_valid_out = (state == RS_SCHED_HOLD);
  assign issue_entry_out = entry_q;
  assign clear_valid_out = fire;
  assign clear_entry_out = entry_q;
endmodule
